// File: rtl/rand_pkg.sv
// Shared definitions for the bounded random value generator.
package rand_pkg;

  localparam int DEFAULT_WIDTH     = 8;
  localparam int DEFAULT_MAX_TRIES = 8;

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    TEST,
    HOLD
  } state_t;

endpackage

// File: rtl/range_mask.sv
// Smears the highest set bit of n_minus_1 downward, giving the smallest 2^k-1 >= n_minus_1.
module range_mask #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] n_minus_1,
  output logic [WIDTH-1:0] mask
);

  always_comb begin
    mask = n_minus_1;
    for (int i = 1; i < WIDTH; i = i * 2) begin
      mask = mask | (mask >> i);
    end
  end

endmodule

// File: rtl/rand_range.sv
// Turns raw LFSR words into a value in [0, N) by masked rejection sampling,
// with a bounded number of retries and a subtract-N fallback.
module rand_range
  import rand_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MAX_TRIES = DEFAULT_MAX_TRIES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [WIDTH-1:0] range_in,
  output logic             ready,
  output logic             rand_en,
  input  logic [WIDTH-1:0] rand_in,
  output logic [WIDTH-1:0] result,
  output logic             valid,
  input  logic             ack
);

  localparam logic [3:0] LAST_TRY = 4'(MAX_TRIES - 1);

  state_t           state;
  logic [WIDTH-1:0] n_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       tries_q;
  logic [WIDTH-1:0] range_m1;
  logic [WIDTH-1:0] mask_next;
  logic [WIDTH-1:0] cand;

  assign range_m1 = range_in - WIDTH'(1);
  assign cand     = rand_in & mask_q;

  range_mask #(.WIDTH(WIDTH)) u_range_mask (
    .n_minus_1 (range_m1),
    .mask      (mask_next)
  );

  assign ready   = (state == IDLE);
  assign valid   = (state == HOLD);
  assign rand_en = (state == DRAW);
  assign result  = result_q;

  // A masked candidate is always below 2N, so the fallback subtraction cannot wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      n_q      <= '0;
      mask_q   <= '0;
      result_q <= '0;
      tries_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            n_q     <= range_in;
            mask_q  <= mask_next;
            tries_q <= '0;
            if (range_in <= WIDTH'(1)) begin
              result_q <= '0;
              state    <= HOLD;
            end else begin
              state <= DRAW;
            end
          end
        end
        DRAW: state <= TEST;
        TEST: begin
          if (cand < n_q) begin
            result_q <= cand;
            state    <= HOLD;
          end else if (tries_q == LAST_TRY) begin
            result_q <= cand - n_q;
            state    <= HOLD;
          end else begin
            tries_q <= tries_q + 4'd1;
            state   <= DRAW;
          end
        end
        HOLD: begin
          if (ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rand_range.sv
// Bench for rand_range: directed vectors, MAX_TRIES=2 fallback, reset abort,
// req/ack overlap in HOLD, and random ranges against a reference model.
module tb_rand_range;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_a, ack_a, ready_a, rand_en_a, valid_a;
  logic [7:0] range_a, lfsr_a, result_a;
  logic       req_b, ack_b, ready_b, rand_en_b, valid_b;
  logic [7:0] range_b, lfsr_b, result_b;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [7:0] n;
    int         exp_res;
    int         exp_lat;
    int         exp_pulses;
  } vec_t;

  vec_t       tbl[5];
  logic [7:0] ref_lfsr;

  always #5 clk = ~clk;

  rand_range dut_a (
    .clk(clk), .reset(reset), .req(req_a), .range_in(range_a), .ready(ready_a),
    .rand_en(rand_en_a), .rand_in(lfsr_a), .result(result_a), .valid(valid_a), .ack(ack_a)
  );

  rand_range #(.WIDTH(8), .MAX_TRIES(2)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .range_in(range_b), .ready(ready_b),
    .rand_en(rand_en_b), .rand_in(lfsr_b), .result(result_b), .valid(valid_b), .ack(ack_b)
  );

  // Upstream XNOR LFSR: 0x00 -> 0x01 -> 0x03 -> 0x07 -> 0x0F -> 0x1E -> 0x3C ...
  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], ~(q[7] ^ q[3])};
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) lfsr_a <= 8'h00;
    else if (rand_en_a) lfsr_a <= lfsr_next(lfsr_a);
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) lfsr_b <= 8'h00;
    else if (rand_en_b) lfsr_b <= lfsr_next(lfsr_b);
  end

  // Rejection sampling restated arithmetically from the draw rules.
  task automatic predict(input int n, input int max_tries, inout logic [7:0] lf,
                         output int res, output int lat, output int pulses);
    int mask;
    int cand;
    res = 0; lat = 1; pulses = 0;
    if (n > 1) begin
      mask = 0;
      while (mask < n - 1) mask = mask * 2 + 1;
      for (int t = 0; t < max_tries; t++) begin
        lf = lfsr_next(lf);
        pulses++;
        cand = int'(lf) & mask;
        lat = 1 + 2 * (t + 1);
        if (cand < n) begin
          res = cand;
          break;
        end else if (t == max_tries - 1) begin
          res = cand - n;
        end
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Runs one request/ack handshake on DUT a (sel=0) or b (sel=1).
  task automatic applyStimulus(input bit sel, input logic [7:0] n, input bit scramble,
                               output int lat, output int pulses, output logic [7:0] res);
    checkOutput("ready_before_req", sel ? ready_b : ready_a, 1);
    if (sel) begin req_b = 1'b1; range_b = n; end
    else     begin req_a = 1'b1; range_a = n; end
    @(posedge clk); #1;
    req_a = 1'b0; req_b = 1'b0;
    if (scramble) begin
      range_a = 8'($urandom);
      range_b = 8'($urandom);
    end
    lat = 1; pulses = 0;
    while (!(sel ? valid_b : valid_a) && lat < 40) begin
      if (sel ? rand_en_b : rand_en_a) pulses++;
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("valid_within_bound", sel ? valid_b : valid_a, 1);
    res = sel ? result_b : result_a;
    if (sel) ack_b = 1'b1; else ack_a = 1'b1;
    @(posedge clk); #1;
    ack_a = 1'b0; ack_b = 1'b0;
    checkOutput("ready_after_ack", sel ? ready_b : ready_a, 1);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, pulses, exp_res, exp_lat, exp_pulses;
    logic [7:0] res, n;

    tbl[0] = '{8'd6, 1, 3, 1};
    tbl[1] = '{8'd6, 3, 3, 1};
    tbl[2] = '{8'd6, 4, 9, 4};
    tbl[3] = '{8'd1, 0, 1, 0};
    tbl[4] = '{8'd0, 0, 1, 0};

    reset = 1'b0;
    req_a = 1'b0; ack_a = 1'b0; range_a = 8'h00;
    req_b = 1'b0; ack_b = 1'b0; range_b = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ready", ready_a, 1);
    checkOutput("reset_valid", valid_a, 0);
    checkOutput("reset_rand_en", rand_en_a, 0);
    checkOutput("reset_result", result_a, 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, tbl[i].n, 1'b0, lat, pulses, res);
      checkOutput($sformatf("tbl%0d_result", i), res, tbl[i].exp_res);
      checkOutput($sformatf("tbl%0d_latency", i), lat, tbl[i].exp_lat);
      checkOutput($sformatf("tbl%0d_pulses", i), pulses, tbl[i].exp_pulses);
    end

    // MAX_TRIES=2: advance the LFSR to 0x03, then both draws reject and fall back.
    applyStimulus(1'b1, 8'd6, 1'b0, lat, pulses, res);
    checkOutput("mt2_first_result", res, 1);
    applyStimulus(1'b1, 8'd6, 1'b0, lat, pulses, res);
    checkOutput("mt2_second_result", res, 3);
    applyStimulus(1'b1, 8'd6, 1'b0, lat, pulses, res);
    checkOutput("mt2_fallback_result", res, 1);
    checkOutput("mt2_fallback_latency", lat, 5);
    checkOutput("mt2_fallback_pulses", pulses, 2);

    // Reset asserted mid-request while in DRAW.
    req_a = 1'b1; range_a = 8'd6;
    @(posedge clk); #1;
    req_a = 1'b0;
    checkOutput("abort_in_draw", rand_en_a, 1);
    reset = 1'b0;
    #1;
    checkOutput("abort_valid", valid_a, 0);
    checkOutput("abort_ready", ready_a, 1);
    checkOutput("abort_rand_en", rand_en_a, 0);
    checkOutput("abort_result", result_a, 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_release_ready", ready_a, 1);
    checkOutput("post_release_valid", valid_a, 0);

    // req held high together with ack while in HOLD.
    ref_lfsr = 8'h00;
    predict(6, 8, ref_lfsr, exp_res, exp_lat, exp_pulses);
    req_a = 1'b1; range_a = 8'd6;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!valid_a && lat < 40);
    checkOutput("overlap_valid", valid_a, 1);
    checkOutput("overlap_result", result_a, exp_res);
    ack_a = 1'b1;
    @(posedge clk); #1;
    checkOutput("overlap_ready", ready_a, 1);
    checkOutput("overlap_no_draw", rand_en_a, 0);
    checkOutput("overlap_valid_low", valid_a, 0);
    req_a = 1'b0; ack_a = 1'b0;
    @(posedge clk); #1;
    checkOutput("overlap_still_idle", ready_a, 1);

    // Random ranges, with range_in scrambled after acceptance.
    for (int i = 0; i < 40; i++) begin
      if (i % 4 == 0) n = 8'($urandom_range(0, 9));
      else            n = 8'($urandom);
      predict(int'(n), 8, ref_lfsr, exp_res, exp_lat, exp_pulses);
      applyStimulus(1'b0, n, 1'b1, lat, pulses, res);
      checkOutput($sformatf("rand%0d_n%0d_result", i, n), res, exp_res);
      checkOutput($sformatf("rand%0d_n%0d_latency", i, n), lat, exp_lat);
      checkOutput($sformatf("rand%0d_n%0d_pulses", i, n), pulses, exp_pulses);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/rand_range.md
RAND_RANGE -- requirements
Module: rand_range

Interface
REQ-001 Parameter: WIDTH, default 8, width of the random word and of the range/result.
REQ-002 Parameter: MAX_TRIES, default 8, number of rejected draws before the fallback result is used (1..15).
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low (0 = reset), applied immediately, released synchronously to clk.
REQ-005 Port: req  input  1  request for a new bounded random value.
REQ-006 Port: range_in  input  WIDTH  exclusive upper bound N; sampled only on acceptance.
REQ-007 Port: ready  output  1  high in IDLE; a request is accepted when req && ready.
REQ-008 Port: rand_en  output  1  enable pulse to the upstream 8-bit LFSR generator.
REQ-009 Port: rand_in  input  WIDTH  current LFSR word from the upstream generator.
REQ-010 Port: result  output  WIDTH  bounded value, 0 <= result < N (result = 0 when N <= 1).
REQ-011 Port: valid  output  1  result is valid; held until ack.
REQ-012 Port: ack  input  1  consumer has taken result.

Function
REQ-013 FSM states: IDLE, DRAW, TEST, HOLD; ready = (state==IDLE), valid = (state==HOLD), rand_en = (state==DRAW).
REQ-014 IDLE: on req && ready, latch N = range_in, latch mask = smallest 2^k-1 >= N-1, clear try counter; if N <= 1 go to HOLD with result = 0 and no rand_en pulse, else go to DRAW.
REQ-015 DRAW: exactly one cycle with rand_en = 1; next state TEST (the LFSR word has advanced when TEST samples it).
REQ-016 TEST: cand = rand_in & mask; if cand < N, result = cand and go to HOLD.
REQ-017 TEST reject (cand >= N): if try counter == MAX_TRIES-1, result = cand - N (always < N because cand < 2N) and go to HOLD; else increment the counter and go to DRAW.
REQ-018 HOLD: result and valid stable; on ack go to IDLE; req is ignored in HOLD, including when req and ack are high in the same cycle.
REQ-019 Latency from the accept edge to valid: 3 cycles best case; +2 cycles per reject; worst case 2*MAX_TRIES+1; N <= 1 gives 1 cycle.
REQ-020 range_in and rand_in changes outside the sampling cycles have no effect.
REQ-021 All compares and subtractions are unsigned, WIDTH bits, with no wrap (guaranteed by REQ-017).

Reset
REQ-022 While reset = 0: state = IDLE, ready = 1, valid = 0, rand_en = 0, result = 0, try counter = 0, latched N and mask = 0.
REQ-023 Reset asserted in any state (including DRAW, TEST or HOLD) aborts the request with no valid pulse; the first cycle after release is IDLE.

Structure
REQ-024 Shared package rand_pkg: FSM state enum, default WIDTH, default MAX_TRIES.
REQ-025 One combinational sub-module range_mask (N-1 in, smeared-ones mask out); the FSM and datapath live in rand_range.

Verification (upstream model: 8-bit XNOR LFSR, reset to 0x00, sequence 0x01,0x03,0x07,0x0F,0x1E,0x3C,0x78,0xF0,0xE0)
REQ-026 Reset, then req with N=6 -> one rand_en pulse; LFSR word 0x01 gives result=1 with valid 3 cycles after accept; ack -> ready=1.
REQ-027 Second req with N=6 -> result=3; third req with N=6 -> words 0x07, 0x0F and 0x1E are rejected (7, 7, 6), word 0x3C is accepted, result=4, valid 9 cycles after accept, 4 rand_en pulses.
REQ-028 MAX_TRIES=2, LFSR at 0x03, req with N=6 -> 0x07 and 0x0F are both rejected -> fallback result=1 (7-6), valid 5 cycles after accept.
REQ-029 req with N=1, then N=0 -> result=0, valid 1 cycle after accept, rand_en never asserted.
REQ-030 reset driven low during DRAW -> valid=0 and ready=1 immediately; req held with ack in HOLD -> one return to IDLE only, no second accept in that cycle.
